// File: rtl/button_event_detector.sv
// Turns per-channel debounced button levels into one-clock press/release strobes,
// an auto-repeat strobe train while a button is held, and a held level.
module button_event_detector #(
  parameter int unsigned width         = 4,
  parameter int unsigned hold_cycles   = 25_000_000,
  parameter int unsigned repeat_cycles = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] debounced_in,
  output logic [width-1:0] press_pulse,
  output logic [width-1:0] release_pulse,
  output logic [width-1:0] repeat_pulse,
  output logic [width-1:0] held
);

  localparam int unsigned MAX_CYCLES = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(hold_cycles - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(repeat_cycles - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_e;

  state_e           state_q [width];
  logic [CNT_W-1:0] cnt_q   [width];
  logic [width-1:0] prev_q;

  // Per-channel FSM; strobes default low so each lasts exactly one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q        <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      held          <= '0;
      for (int i = 0; i < int'(width); i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      prev_q        <= debounced_in;
      press_pulse   <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      for (int i = 0; i < int'(width); i++) begin
        unique case (state_q[i])
          IDLE: begin
            cnt_q[i] <= '0;
            if (debounced_in[i] && !prev_q[i]) begin
              state_q[i]     <= PRESSED;
              press_pulse[i] <= 1'b1;
              held[i]        <= 1'b1;
            end
          end
          PRESSED, REPEAT: begin
            // Release takes priority over a coinciding terminal count.
            if (!debounced_in[i]) begin
              state_q[i]       <= IDLE;
              cnt_q[i]         <= '0;
              release_pulse[i] <= 1'b1;
              held[i]          <= 1'b0;
            end else if ((state_q[i] == PRESSED && cnt_q[i] == HOLD_LAST) ||
                         (state_q[i] == REPEAT  && cnt_q[i] == REPEAT_LAST)) begin
              state_q[i]      <= REPEAT;
              cnt_q[i]        <= '0;
              repeat_pulse[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            held[i]    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector: table vectors plus scenario sequences,
// expected outputs queued at drive time and compared after the next edge.
module tb_button_event_detector;

  localparam int unsigned W    = 4;
  localparam int          HOLD = 8;
  localparam int          REP  = 4;

  typedef struct packed {
    logic [W-1:0] press;
    logic [W-1:0] rel;
    logic [W-1:0] rpt;
    logic [W-1:0] held;
  } out_t;

  typedef struct {
    logic         rst;
    logic [W-1:0] din;
    out_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] debounced_in = '0;
  logic [W-1:0] press_pulse, release_pulse, repeat_pulse, held;

  button_event_detector #(
    .width        (W),
    .hold_cycles  (HOLD),
    .repeat_cycles(REP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .debounced_in (debounced_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";
  out_t  exp_q[$];
  int    rpt_seen[W];

  // Reference model: tracks edges elapsed since the press edge per channel.
  logic [W-1:0] m_prev = '0;
  bit           m_act[W];
  int           m_age[W];

  task automatic model_step(input logic r, input logic [W-1:0] v, output out_t o);
    o = '0;
    for (int c = 0; c < int'(W); c++) begin
      if (r) begin
        m_act[c] = 1'b0;
        m_age[c] = 0;
      end else if (!m_act[c]) begin
        if (v[c] && !m_prev[c]) begin
          m_act[c]   = 1'b1;
          m_age[c]   = 0;
          o.press[c] = 1'b1;
          o.held[c]  = 1'b1;
        end
      end else begin
        m_age[c] = m_age[c] + 1;
        if (!v[c]) begin
          m_act[c] = 1'b0;
          o.rel[c] = 1'b1;
        end else begin
          o.held[c] = 1'b1;
          if (m_age[c] >= HOLD && ((m_age[c] - HOLD) % REP) == 0) o.rpt[c] = 1'b1;
        end
      end
    end
    m_prev = r ? '0 : v;
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic drive(input logic r, input logic [W-1:0] v, input bit use_tab, input out_t texp);
    out_t m;
    @(negedge clk);
    rst          = r;
    debounced_in = v;
    model_step(r, v, m);
    exp_q.push_back(use_tab ? texp : m);
  endtask

  task automatic drive_m(input logic r, input logic [W-1:0] v);
    drive(r, v, 1'b0, '0);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic clear_seen();
    for (int c = 0; c < int'(W); c++) rpt_seen[c] = 0;
  endtask

  // Scoreboard: pop one expectation per edge once stimulus has been queued.
  always @(posedge clk) begin
    out_t e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{press: press_pulse, rel: release_pulse, rpt: repeat_pulse, held: held};
      for (int c = 0; c < int'(W); c++) if (g.rpt[c]) rpt_seen[c]++;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s @%0t: got press=%h rel=%h rpt=%h held=%h, expected press=%h rel=%h rpt=%h held=%h",
                 phase, $time, g.press, g.rel, g.rpt, g.held, e.press, e.rel, e.rpt, e.held);
      end
    end
  end

  function automatic vec_t mk(input logic r, input logic [W-1:0] v, input logic [W-1:0] p,
                              input logic [W-1:0] rl, input logic [W-1:0] rp, input logic [W-1:0] h);
    vec_t t;
    t.rst = r;
    t.din = v;
    t.exp = '{press: p, rel: rl, rpt: rp, held: h};
    return t;
  endfunction

  vec_t tab[11];

  initial begin
    // Reset with all inputs high, press on release of reset, then a one-clock ch2 blip.
    tab[0]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    tab[1]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    tab[2]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    tab[3]  = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF);
    tab[4]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
    tab[5]  = mk(1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    tab[6]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tab[7]  = mk(1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4);
    tab[8]  = mk(1'b0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
    tab[9]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tab[10] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    clear_seen();
    phase = "table";
    for (int i = 0; i < 11; i++) drive(tab[i].rst, tab[i].din, 1'b1, tab[i].exp);
    drain();

    // ch0 held 30 clocks: six repeats expected.
    phase = "ch0_hold30";
    clear_seen();
    for (int i = 0; i < 30; i++) drive_m(1'b0, 4'h1);
    for (int i = 0; i < 4; i++)  drive_m(1'b0, 4'h0);
    drain();
    check_int("ch0_repeat_count", rpt_seen[0], 6);

    // ch1 released on the edge where the hold counter is terminal: no repeat.
    phase = "ch1_release_on_terminal";
    clear_seen();
    for (int i = 0; i < HOLD; i++) drive_m(1'b0, 4'h2);
    for (int i = 0; i < 4; i++)    drive_m(1'b0, 4'h0);
    drain();
    check_int("ch1_no_repeat", rpt_seen[1], 0);

    // ch0 and ch3 pressed two clocks apart, each held 20 clocks.
    phase = "ch0_ch3_offset";
    clear_seen();
    for (int k = 0; k < 26; k++) begin
      logic [W-1:0] v;
      v    = '0;
      v[0] = (k < 20);
      v[3] = (k >= 2 && k < 22);
      drive_m(1'b0, v);
    end
    drain();
    check_int("ch0_offset_repeats", rpt_seen[0], 3);
    check_int("ch3_offset_repeats", rpt_seen[3], 3);
    check_int("ch1_quiet", rpt_seen[1], 0);

    // Reset mid-REPEAT on ch1 with the input still high.
    phase = "ch1_rst_mid_repeat";
    clear_seen();
    for (int i = 0; i < 12; i++) drive_m(1'b0, 4'h2);
    drive_m(1'b1, 4'h2);
    for (int i = 0; i < 14; i++) drive_m(1'b0, 4'h2);
    for (int i = 0; i < 3; i++)  drive_m(1'b0, 4'h0);
    drain();
    check_int("ch1_rst_repeats", rpt_seen[1], 3);

    // Random multi-channel activity against the model.
    phase = "random";
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] v;
      v = W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) v = m_prev ^ (W'(1) << $urandom_range(0, W - 1));
      drive_m(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, v);
    end
    drain();

    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
